// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO control slice: state encoding and default pointer width.
package fifo_pkg;

    localparam int AW_DEF = 4;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    typedef enum logic [1:0] {
        S_EMPTY  = ST_EMPTY,
        S_ACTIVE = ST_ACTIVE,
        S_FULL   = ST_FULL,
        S_FLUSH  = ST_FLUSH
    } state_e;

endpackage

// File: rtl/fifo_if.sv
// Request/acknowledge, pointer-control and status bundle between the FIFO controller and its users.
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int AW = AW_DEF
);
    logic          wr_req;
    logic          rd_req;
    logic          flush;
    logic          err_clr;
    logic          wr_ack;
    logic          rd_ack;
    logic          mem_we;
    logic          inc_wr_ptr;
    logic          inc_rd_ptr;
    logic          clr_wr_ptr;
    logic          clr_rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;

    // Controller side
    modport slave (
        input  wr_req, rd_req, flush, err_clr,
        output wr_ack, rd_ack, mem_we, inc_wr_ptr, inc_rd_ptr,
        output clr_wr_ptr, clr_rd_ptr, count, full, empty, overflow, underflow
    );

    // Producer/consumer/datapath side
    modport master (
        output wr_req, rd_req, flush, err_clr,
        input  wr_ack, rd_ack, mem_we, inc_wr_ptr, inc_rd_ptr,
        input  clr_wr_ptr, clr_rd_ptr, count, full, empty, overflow, underflow
    );

endinterface

// File: rtl/fifo_occ_cnt.sv
// Up/down occupancy counter with synchronous clear; also exposes its next value so the
// controller FSM can decide its next state from the same edge's update.
module fifo_occ_cnt
    import fifo_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic        ck,
    input  logic        clr_i,
    input  logic        up_i,
    input  logic        dn_i,
    output logic [AW:0] count_o,
    output logic [AW:0] count_d_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

    logic [AW:0] count_q;
    logic [AW:0] count_d;
    logic        full_q;
    logic        empty_q;

    // Simultaneous up and down cancel out.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (up_i && !dn_i) begin
            count_d = count_q + ONE_C;
        end else if (dn_i && !up_i) begin
            count_d = count_q - ONE_C;
        end
    end

    always_ff @(posedge ck) begin
        count_q <= count_d;
        full_q  <= (count_d == DEPTH_C);
        empty_q <= (count_d == '0);
    end

    assign count_o   = count_q;
    assign count_d_o = count_d;
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control: accepts/rejects requests, drives pointer clr/inc and RAM write enable,
// runs the EMPTY/ACTIVE/FULL/FLUSH state machine and keeps sticky overflow/underflow flags.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic  ck,
    input  logic  reset,
    fifo_if.slave bus
);

    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

    state_e      state_q;
    state_e      state_d;
    logic        overflow_q;
    logic        overflow_d;
    logic        underflow_q;
    logic        underflow_d;

    logic        in_flush;
    logic        wr_ack;
    logic        rd_ack;
    logic        cnt_clr;
    logic [AW:0] count;
    logic [AW:0] count_d;
    logic        full;
    logic        empty;

    assign in_flush = (state_q == S_FLUSH);

    // A full FIFO rejects writes even when a read is accepted alongside; likewise for empty.
    assign wr_ack = bus.wr_req & ~full  & ~bus.flush & ~in_flush & ~reset;
    assign rd_ack = bus.rd_req & ~empty & ~bus.flush & ~in_flush & ~reset;

    // Occupancy drops to zero at the flush edge; the pointers follow one cycle later.
    assign cnt_clr = reset | (bus.flush & ~in_flush);

    fifo_occ_cnt #(
        .AW (AW)
    ) u_occ (
        .ck        (ck),
        .clr_i     (cnt_clr),
        .up_i      (wr_ack),
        .dn_i      (rd_ack),
        .count_o   (count),
        .count_d_o (count_d),
        .full_o    (full),
        .empty_o   (empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FLUSH: state_d = S_EMPTY;
            default: begin
                if (bus.flush) begin
                    state_d = S_FLUSH;
                end else if (count_d == '0) begin
                    state_d = S_EMPTY;
                end else if (count_d == DEPTH_C) begin
                    state_d = S_FULL;
                end else begin
                    state_d = S_ACTIVE;
                end
            end
        endcase
    end

    // Setting wins over err_clr in the same cycle.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.wr_req && full && !bus.flush) begin
            overflow_d = 1'b1;
        end else if (bus.err_clr) begin
            overflow_d = 1'b0;
        end
        if (bus.rd_req && empty && !bus.flush) begin
            underflow_d = 1'b1;
        end else if (bus.err_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.wr_ack     = wr_ack;
    assign bus.rd_ack     = rd_ack;
    assign bus.mem_we     = wr_ack;
    assign bus.inc_wr_ptr = wr_ack;
    assign bus.inc_rd_ptr = rd_ack;
    assign bus.clr_wr_ptr = reset | in_flush;
    assign bus.clr_rd_ptr = reset | in_flush;
    assign bus.count      = count;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: a table of per-cycle vectors with a scoreboard of post-edge
// expectations, followed by hand-written fill/overflow/reset sequences.
module tb_fifo_ctrl;

    logic ck;
    logic reset;

    fifo_if bus ();

    fifo_ctrl dut (
        .ck    (ck),
        .reset (reset),
        .bus   (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        logic rst, wr, rd, fl, ec;
        logic wa, ra, clr;
        int   cnt;
        logic full, empty, ovf, unf;
    } vec_t;

    typedef struct {
        int   idx;
        int   cnt;
        logic full, empty, ovf, unf;
    } post_t;

    vec_t  vecs[$];
    post_t sb[$];
    int    total = 0;
    int    bad   = 0;

    function automatic void add(input logic rst, wr, rd, fl, ec, wa, ra, clr,
                                input int cnt, input logic full, empty, ovf, unf);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.fl = fl; v.ec = ec;
        v.wa = wa; v.ra = ra; v.clr = clr;
        v.cnt = cnt; v.full = full; v.empty = empty; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endfunction

    task automatic chk1(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%b want=%b", name, idx, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        post_t p;
        post_t q;
        @(negedge ck);
        reset       = v.rst;
        bus.wr_req  = v.wr;
        bus.rd_req  = v.rd;
        bus.flush   = v.fl;
        bus.err_clr = v.ec;
        #1;
        chk1("wr_ack", idx, bus.wr_ack, v.wa);
        chk1("mem_we", idx, bus.mem_we, v.wa);
        chk1("inc_wr_ptr", idx, bus.inc_wr_ptr, v.wa);
        chk1("rd_ack", idx, bus.rd_ack, v.ra);
        chk1("inc_rd_ptr", idx, bus.inc_rd_ptr, v.ra);
        chk1("clr_wr_ptr", idx, bus.clr_wr_ptr, v.clr);
        chk1("clr_rd_ptr", idx, bus.clr_rd_ptr, v.clr);
        p.idx = idx; p.cnt = v.cnt; p.full = v.full; p.empty = v.empty;
        p.ovf = v.ovf; p.unf = v.unf;
        sb.push_back(p);
        @(posedge ck);
        #1;
        q = sb.pop_front();
        chkn("count", q.idx, int'(bus.count), q.cnt);
        chk1("full", q.idx, bus.full, q.full);
        chk1("empty", q.idx, bus.empty, q.empty);
        chk1("overflow", q.idx, bus.overflow, q.ovf);
        chk1("underflow", q.idx, bus.underflow, q.unf);
        $display("vec %0d rst=%b wr=%b rd=%b fl=%b ec=%b -> wa=%b ra=%b count=%0d full=%b empty=%b ovf=%b unf=%b",
                 idx, v.rst, v.wr, v.rd, v.fl, v.ec, bus.wr_ack, bus.rd_ack,
                 bus.count, bus.full, bus.empty, bus.overflow, bus.underflow);
    endtask

    initial begin
        int acks;
        int cycles;

        reset       = 1'b1;
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.flush   = 1'b0;
        bus.err_clr = 1'b0;

        // Reset state
        add(1,0,0,0,0, 0,0,1, 0,0,1,0,0);
        add(1,0,0,0,0, 0,0,1, 0,0,1,0,0);
        // Fill to full, then a rejected write sets overflow
        for (int i = 0; i < 16; i++) add(0,1,0,0,0, 1,0,0, i+1, (i == 15), 0,0,0);
        add(0,1,0,0,0, 0,0,0, 16,1,0,1,0);
        // err_clr with a new overflow keeps the flag; err_clr alone clears it
        add(0,1,0,0,1, 0,0,0, 16,1,0,1,0);
        add(0,0,0,0,1, 0,0,0, 16,1,0,0,0);
        // Drain to empty, then a rejected read sets underflow, then clear
        for (int i = 0; i < 16; i++) add(0,0,1,0,0, 0,1,0, 15-i, 0, (i == 15), 0,0);
        add(0,0,1,0,0, 0,0,0, 0,0,1,0,1);
        add(0,0,0,0,1, 0,0,0, 0,0,1,0,0);
        // Simultaneous traffic at count 5
        for (int i = 0; i < 5; i++) add(0,1,0,0,0, 1,0,0, i+1, 0,0,0,0);
        for (int i = 0; i < 4; i++) add(0,1,1,0,0, 1,1,0, 5, 0,0,0,0);
        for (int i = 0; i < 11; i++) add(0,1,0,0,0, 1,0,0, 6+i, (i == 10), 0,0,0);
        // Both requests while full: only the read goes through, and the write counts as overflow
        add(0,1,1,0,0, 0,1,0, 15,0,0,1,0);
        add(0,0,0,0,1, 0,0,0, 15,0,0,0,0);
        // Down to 9, flush with a concurrent write, then the pointer-clear cycle
        for (int i = 0; i < 6; i++) add(0,0,1,0,0, 0,1,0, 14-i, 0,0,0,0);
        add(0,1,0,1,0, 0,0,0, 0,0,1,0,0);
        add(0,1,0,1,0, 0,0,1, 0,0,1,0,0);
        add(0,1,0,0,0, 1,0,0, 1,0,0,0,0);
        // Reset at count 7 with both requests pending
        for (int i = 0; i < 6; i++) add(0,1,0,0,0, 1,0,0, 2+i, 0,0,0,0);
        add(1,1,1,0,0, 0,0,1, 0,0,1,0,0);
        add(0,1,0,0,0, 1,0,0, 1,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Fill from 1 to full with a bounded cycle budget
        acks   = 0;
        cycles = 0;
        while (cycles < 40) begin
            @(negedge ck);
            reset = 1'b0; bus.wr_req = 1'b1; bus.rd_req = 1'b0;
            bus.flush = 1'b0; bus.err_clr = 1'b0;
            #1;
            if (bus.wr_ack) acks++;
            @(posedge ck);
            #1;
            cycles++;
            if (bus.full) break;
        end
        chkn("fill_acks", -1, acks, 15);
        chk1("fill_full", -1, bus.full, 1'b1);
        $display("seq fill: acks=%0d cycles=%0d count=%0d full=%b", acks, cycles, bus.count, bus.full);

        // Overflow, then reset clears flags and occupancy
        @(negedge ck);
        bus.wr_req = 1'b1;
        @(posedge ck);
        #1;
        chk1("seq_ovf_set", -1, bus.overflow, 1'b1);
        @(negedge ck);
        reset = 1'b1;
        #1;
        chk1("seq_rst_clr", -1, bus.clr_wr_ptr, 1'b1);
        chk1("seq_rst_noack", -1, bus.wr_ack, 1'b0);
        @(posedge ck);
        #1;
        chk1("seq_rst_ovf", -1, bus.overflow, 1'b0);
        chkn("seq_rst_count", -1, int'(bus.count), 0);
        chk1("seq_rst_empty", -1, bus.empty, 1'b1);
        $display("seq reset: ovf=%b count=%0d empty=%b", bus.overflow, bus.count, bus.empty);

        @(negedge ck);
        reset = 1'b0;
        bus.wr_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
